// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 tap array.
// A window is emitted one cycle after each accepted pixel at row>=2, col>=2.
module window_3x3_gen #(
  parameter int DATA_W = 13,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  output logic              out_eof,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p7,
  output logic [DATA_W-1:0] p8
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-1:0]     cur_col;
  logic [RW-1:0]     cur_row;
  logic              last_col;
  logic              last_row;
  logic              emit;

  logic [DATA_W-1:0] lb_a [IMG_W];
  logic [DATA_W-1:0] lb_b [IMG_W];
  logic [DATA_W-1:0] a_rd;
  logic [DATA_W-1:0] b_rd;

  logic [DATA_W-1:0] win_p0  [9];
  logic [DATA_W-1:0] win_nxt [9];
  logic [DATA_W-1:0] win_p1  [9];
  logic              vld_p1;
  logic              eof_p1;

  // Stage 0: position of the accepted pixel; in_sof overrides the counters
  assign cur_col  = in_sof ? '0 : col;
  assign cur_row  = in_sof ? '0 : row;
  assign last_col = (cur_col == CW'(IMG_W - 1));
  assign last_row = (cur_row == RW'(IMG_H - 1));
  assign emit     = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  assign a_rd = lb_a[cur_col];
  assign b_rd = lb_b[cur_col];

  always_comb begin
    win_nxt[0] = win_p0[1];
    win_nxt[1] = win_p0[2];
    win_nxt[2] = b_rd;
    win_nxt[3] = win_p0[4];
    win_nxt[4] = win_p0[5];
    win_nxt[5] = a_rd;
    win_nxt[6] = win_p0[7];
    win_nxt[7] = win_p0[8];
    win_nxt[8] = in_pixel;
  end

  // Line buffers are never cleared: stale lines are unreachable before row 2
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb_a[cur_col] <= in_pixel;
      lb_b[cur_col] <= a_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      win_p0 <= '{default: '0};
      win_p1 <= '{default: '0};
      vld_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      if (in_valid) begin
        win_p0 <= win_nxt;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
        // Stage 1: outputs hold between windows, so load only on emission
        if (emit) begin
          win_p1 <= win_nxt;
          vld_p1 <= 1'b1;
          eof_p1 <= last_row && last_col;
        end
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_eof   = eof_p1;
  assign p0 = win_p1[0];
  assign p1 = win_p1[1];
  assign p2 = win_p1[2];
  assign p3 = win_p1[3];
  assign p4 = win_p1[4];
  assign p5 = win_p1[5];
  assign p6 = win_p1[6];
  assign p7 = win_p1[7];
  assign p8 = win_p1[8];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen: a frame-memory model queues expected
// windows at stimulus time, and a monitor pops and checks on every out_valid.
module tb_window_3x3_gen;
  localparam int DW = 13;
  localparam int W  = 64;
  localparam int H  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_pixel;
  logic          out_valid;
  logic          out_eof;
  logic [DW-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [9*DW-1:0] act;

  window_3x3_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .out_valid(out_valid), .out_eof(out_eof),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
    .p5(p5), .p6(p6), .p7(p7), .p8(p8)
  );

  assign act = {p8, p7, p6, p5, p4, p3, p2, p1, p0};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run  = 0;
  int n_fail = 0;

  logic [DW-1:0]   img [H][W];
  int              br = 0;
  int              bc = 0;
  logic [9*DW-1:0] qp [$];
  logic            qe [$];
  int              qc [$];

  int n_win   = 0;
  int n_eof   = 0;
  int win_idx = 0;
  bit ramp_chk = 1'b0;
  int first_exp [9] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] r);
    n_run++;
    if (a !== r) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, a, r);
    end
  endtask

  // Drive one cycle of input at the falling edge; accepted pixels update the model
  task automatic drive(input bit v, input bit s, input logic [DW-1:0] px);
    logic [9*DW-1:0] e;
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_pixel = px;
    if (v) begin
      if (s) begin
        br = 0;
        bc = 0;
      end
      img[br][bc] = px;
      if (br >= 2 && bc >= 2) begin
        for (int k = 0; k < 9; k++)
          e[k*DW +: DW] = img[br-2+k/3][bc-2+k%3];
        qp.push_back(e);
        qe.push_back(br == H-1 && bc == W-1);
        qc.push_back(cyc + 1);
      end
      bc++;
      if (bc == W) begin
        bc = 0;
        br++;
        if (br == H) br = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom_range(1)), DW'($urandom));
  endtask

  task automatic start_phase(input bit rc);
    n_win    = 0;
    n_eof    = 0;
    win_idx  = 0;
    ramp_chk = rc;
  endtask

  task automatic ramp_frame(input bit gapped, input bit with_sof);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gapped)
          while ($urandom_range(1) == 0) idle(1);
        drive(1'b1, with_sof && r == 0 && c == 0, DW'(r*W + c));
      end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (qp.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_window: got out_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        logic [9*DW-1:0] ep;
        logic            ee;
        int              ec;
        ep = qp.pop_front();
        ee = qe.pop_front();
        ec = qc.pop_front();
        n_run++;
        if (act !== ep || out_eof !== ee || cyc != ec) begin
          n_fail++;
          $display("FAIL window: got p=%h eof=%b cyc=%0d, expected p=%h eof=%b cyc=%0d",
                   act, out_eof, cyc, ep, ee, ec);
        end
        if (ramp_chk) begin
          if (win_idx == 0)
            for (int k = 0; k < 9; k++)
              chk($sformatf("first_p%0d", k), 32'(act[k*DW +: DW]), first_exp[k]);
          if (win_idx == 62) begin
            chk("row3_p0", 32'(p0), 64);
            chk("row3_p8", 32'(p8), 194);
          end
          if (win_idx == 3843) begin
            chk("last_p8", 32'(p8), 4095);
            chk("last_p4", 32'(p4), 4030);
            chk("last_p0", 32'(p0), 3965);
            chk("last_eof", 32'(out_eof), 1);
          end
        end
        n_win++;
        if (out_eof === 1'b1) n_eof++;
        win_idx++;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_eof", 32'(out_eof), 0);
    chk("rst_p_zero", 32'(|act), 0);

    // Ramp frame, back to back
    start_phase(1'b1);
    ramp_frame(1'b0, 1'b1);
    idle(3);
    chk("ramp_windows", n_win, 3844);
    chk("ramp_eof", n_eof, 1);

    // Gapped ramp
    start_phase(1'b1);
    ramp_frame(1'b1, 1'b1);
    idle(3);
    chk("gap_windows", n_win, 3844);
    chk("gap_eof", n_eof, 1);

    // Aborted frame after 1000 pixels, then restart with in_sof
    start_phase(1'b0);
    for (int i = 0; i < 1000; i++)
      drive(1'b1, i == 0, DW'(i));
    idle(3);
    chk("abort_windows", n_win, 844);
    chk("abort_eof", n_eof, 0);
    start_phase(1'b1);
    ramp_frame(1'b0, 1'b1);
    idle(3);
    chk("restart_windows", n_win, 3844);
    chk("restart_eof", n_eof, 1);

    // Reset mid-frame at pixel 2000, then a frame with no in_sof
    start_phase(1'b0);
    for (int i = 0; i < 2000; i++)
      drive(1'b1, i == 0, DW'(i));
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    br = 0;
    bc = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_p_zero", 32'(|act), 0);
    chk("midrst_queue", qp.size(), 0);
    start_phase(1'b1);
    ramp_frame(1'b0, 1'b0);
    idle(3);
    chk("nosof_windows", n_win, 3844);
    chk("nosof_eof", n_eof, 1);

    // Full-scale data, two back-to-back frames
    start_phase(1'b0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < W*H; i++)
        drive(1'b1, i == 0, DW'(8191));
    idle(3);
    chk("full_windows", n_win, 7688);
    chk("full_eof", n_eof, 2);
    chk("full_p4", 32'(p4), 8191);

    chk("queue_empty", qp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3x3 window generator for the 64x64 filter pipeline. It accepts one raster-order pixel per valid cycle and buffers two image lines internally. It presents the nine pixels of each fully-interior 3x3 neighbourhood on p0..p8, which is the port set the kernel_3x3 convolution stage consumes directly. Border windows are not produced: a WxH frame yields (W-2)x(H-2) windows.

## Interface
Parameters:
- DATA_W, 13: pixel width in bits.
- IMG_W, 64: pixels per line. Must be at least 3.
- IMG_H, 64: lines per frame. Must be at least 3.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_pixel is accepted this cycle. There is no backpressure: the block is always ready.
- in_sof  input  1  qualifies in_pixel as pixel (0,0) of a new frame. Ignored unless in_valid is high.
- in_pixel  input  DATA_W  input pixel, raster order, row-major.
- out_valid  output  1  window outputs are valid this cycle (one-cycle pulse per window).
- out_eof  output  1  high with out_valid on the last window of the frame.
- p0,p1,p2  output  DATA_W each  top row of the window, left to right (oldest line).
- p3,p4,p5  output  DATA_W each  middle row of the window, left to right.
- p6,p7,p8  output  DATA_W each  bottom row of the window, left to right (current line).

## Operation
Counters:
- col counts 0..IMG_W-1 and row counts 0..IMG_H-1.
- Both advance only on accepted pixels (in_valid=1).
- col wraps to 0 after IMG_W-1, and row then increments.
- After pixel (IMG_H-1, IMG_W-1), both counters wrap to (0,0) for the next frame.
- in_valid=1 with in_sof=1 forces the accepted pixel to position (0,0), whatever the counter state. Counters then continue from (0,1).

Line buffers:
- Two IMG_W-deep buffers, indexed by col.
- Line buffer A holds row r-1 and line buffer B holds row r-2.
- On each accepted pixel at column c:
  - read A[c] and B[c];
  - write A[c] <= in_pixel;
  - write B[c] <= old A[c].

Window shift registers:
- Three rows of three taps.
- Each accepted pixel shifts the taps left and loads B[c], A[c] and in_pixel into the right column (p2, p5, p8 positions).
- Taps do not move on idle cycles.

Window emission:
- When the pixel accepted at (r,c) has r>=2 and c>=2, the next cycle presents the window centred on (r-1,c-1):
  - p0 = pixel(r-2,c-2), p4 = pixel(r-1,c-1), p8 = pixel(r,c).
  - out_valid=1 for that cycle.
  - out_eof=1 if r=IMG_H-1 and c=IMG_W-1.
- No window is emitted for c<2, so windows never straddle a line wrap.
- The window values seen at row-start columns 0 and 1 are internal only and are never flagged valid.

Line buffer contents are never cleared. Stale data is unreachable because emission requires r>=2.

## Timing
- Latency: exactly 1 cycle from the qualifying accepted input to out_valid, with p0..p8 and out_eof registered.
- out_valid and out_eof are single-cycle pulses. Between pulses, p0..p8 hold their last values.
- Throughput: one window per cycle at full input rate. Arbitrary in_valid gaps are allowed; output pulses follow accepted inputs 1:1 with a one-cycle shift.
- Reset values: out_valid=0, out_eof=0, p0..p8=0, col=0, row=0, window taps=0.
- rst asserted mid-frame: the next cycle has out_valid=0. The next accepted pixel is (0,0) whether or not in_sof is set.
- in_sof mid-frame: the partial frame is abandoned and no out_eof is issued for it. No window is emitted until row 2, col 2 of the new frame.
- in_sof asserted with in_valid=0: no effect.
- No arithmetic is performed; data widths pass through unchanged at DATA_W.

## Test plan
- **Ramp frame.** Reset, then drive 4096 pixels back-to-back with value r*64+c and in_sof on the first pixel.
  - First out_valid occurs one cycle after pixel (2,2) is accepted, with p0..p8 = 0,1,2,64,65,66,128,129,130.
  - 3844 out_valid pulses occur in total.
  - The last pulse has out_eof=1 and p8=4095, p4=4030, p0=3965.
- **Row boundary.** Same ramp: no out_valid follows the pixels at columns 0 and 1 of any row.
  - The window after pixel (3,2) has p0=64, p8=194.
- **Gapped input.** Ramp with in_valid toggling at random at roughly 50% duty.
  - The window sequence and values match the ramp case exactly.
  - Every out_valid occurs exactly one cycle after an accepted qualifying pixel.
- **Mid-frame restart.** Stop after 1000 pixels, then start a new ramp with in_sof.
  - The first window appears only after new pixel (2,2), with the same values as the ramp case.
  - No out_eof is issued for the aborted frame.
- **Reset mid-frame.** Assert rst at pixel 2000.
  - The next cycle has out_valid=0, and all p outputs read 0 until the next window.
  - A following frame sent without in_sof still produces 3844 correct windows.
- **Full-scale data.** A frame of all 8191 gives every p output = 8191 on all 3844 windows.
  - Back-to-back frames produce out_eof once per frame.
